// File: rtl/hpdmc_dqcal.sv
// DQ input-delay calibration: sweeps the delay line tap by tap with test reads,
// measures the first passing window, then parks the delay at the window centre.
module hpdmc_dqcal #(
    parameter int unsigned TAPS    = 64,
    parameter logic [31:0] PATTERN = 32'hA55A5AA5,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic        rd_valid,
    input  logic [31:0] di,
    output logic        idelay_rst,
    output logic        idelay_ce,
    output logic        idelay_inc,
    output logic [7:0]  tap,
    output logic [7:0]  win_lo,
    output logic [7:0]  win_hi
);
    typedef enum logic [3:0] {
        S_IDLE, S_ZERO, S_REQ, S_WAIT, S_STEP,
        S_SETTLE, S_REZERO, S_CENTER, S_CSETTLE, S_END
    } state_t;

    localparam logic [7:0] LAST_TAP    = 8'(TAPS - 1);
    localparam logic [3:0] SETTLE_CNT  = 4'(SETTLE);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     r_state, w_state;
    logic       r_busy, w_busy;
    logic       r_done, w_done;
    logic       r_fail, w_fail;
    logic       r_rdReq, w_rdReq;
    logic       r_idelayRst, w_idelayRst;
    logic       r_idelayCe, w_idelayCe;
    logic [7:0] r_tap, w_tap;
    logic [7:0] r_winLo, w_winLo;
    logic [7:0] r_winHi, w_winHi;
    logic       r_found, w_found;
    logic [7:0] r_target, w_target;
    logic [3:0] r_cnt, w_cnt;
    logic [7:0] r_tcnt, w_tcnt;
    logic       w_pass;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_rdReq     <= 1'b0;
            r_idelayRst <= 1'b0;
            r_idelayCe  <= 1'b0;
            r_tap       <= 8'd0;
            r_winLo     <= 8'd0;
            r_winHi     <= 8'd0;
            r_found     <= 1'b0;
            r_target    <= 8'd0;
            r_cnt       <= 4'd0;
            r_tcnt      <= 8'd0;
        end else begin
            r_state     <= w_state;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_fail      <= w_fail;
            r_rdReq     <= w_rdReq;
            r_idelayRst <= w_idelayRst;
            r_idelayCe  <= w_idelayCe;
            r_tap       <= w_tap;
            r_winLo     <= w_winLo;
            r_winHi     <= w_winHi;
            r_found     <= w_found;
            r_target    <= w_target;
            r_cnt       <= w_cnt;
            r_tcnt      <= w_tcnt;
        end
    end

    assign w_pass = (di == PATTERN);

    always_comb begin
        w_state     = r_state;
        w_busy      = r_busy;
        w_done      = r_done;
        w_fail      = r_fail;
        w_rdReq     = 1'b0;
        w_idelayRst = 1'b0;
        w_idelayCe  = 1'b0;
        w_tap       = r_tap;
        w_winLo     = r_winLo;
        w_winHi     = r_winHi;
        w_found     = r_found;
        w_target    = r_target;
        w_cnt       = r_cnt;
        w_tcnt      = r_tcnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_ZERO;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_fail  = 1'b0;
                    w_winLo = 8'd0;
                    w_winHi = 8'd0;
                    w_found = 1'b0;
                end
            end
            S_ZERO: begin
                w_idelayRst = 1'b1;
                w_tap       = 8'd0;
                w_cnt       = SETTLE_CNT;
                w_state     = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_REQ;
                    w_rdReq = 1'b1;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    w_tcnt  = TIMEOUT_CNT;
                    w_state = S_WAIT;
                end else begin
                    w_rdReq = 1'b1;
                end
            end
            // A data strobe wins over timeout expiry in the same cycle.
            S_WAIT: begin
                if (rd_valid) begin
                    if (w_pass) begin
                        w_winHi = r_tap;
                        w_found = 1'b1;
                        if (!r_found) begin
                            w_winLo = r_tap;
                        end
                    end
                    if (!w_pass && r_found) begin
                        w_state = S_REZERO;
                    end else if (r_tap == LAST_TAP) begin
                        if (w_pass) begin
                            w_state = S_REZERO;
                        end else begin
                            w_state = S_END;
                            w_fail  = 1'b1;
                            w_busy  = 1'b0;
                        end
                    end else begin
                        w_state = S_STEP;
                    end
                end else if (r_tcnt <= 8'd1) begin
                    w_state = S_END;
                    w_fail  = 1'b1;
                    w_busy  = 1'b0;
                end else begin
                    w_tcnt = r_tcnt - 8'd1;
                end
            end
            S_STEP: begin
                w_idelayCe = 1'b1;
                w_tap      = r_tap + 8'd1;
                w_cnt      = SETTLE_CNT;
                w_state    = S_SETTLE;
            end
            S_REZERO: begin
                w_idelayRst = 1'b1;
                w_tap       = 8'd0;
                w_target    = 8'(({1'b0, r_winLo} + {1'b0, r_winHi}) >> 1);
                w_cnt       = SETTLE_CNT;
                w_state     = S_CSETTLE;
            end
            S_CSETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_CENTER;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_CENTER: begin
                if (r_tap == r_target) begin
                    w_state = S_END;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else begin
                    w_idelayCe = 1'b1;
                    w_tap      = r_tap + 8'd1;
                    w_cnt      = SETTLE_CNT;
                    w_state    = S_CSETTLE;
                end
            end
            S_END: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign rd_req     = r_rdReq;
    assign idelay_rst = r_idelayRst;
    assign idelay_ce  = r_idelayCe;
    assign idelay_inc = 1'b1;
    assign tap        = r_tap;
    assign win_lo     = r_winLo;
    assign win_hi     = r_winHi;

endmodule

// File: tb/tb_hpdmc_dqcal.sv
// Bench for hpdmc_dqcal: a delay-line model plus a read responder that returns
// the expected pattern only inside a configurable tap window.
module tb_hpdmc_dqcal;
    localparam int          TAPS    = 64;
    localparam int          SETTLE  = 4;
    localparam int          TIMEOUT = 255;
    localparam logic [31:0] PATTERN = 32'hA55A5AA5;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic        busy, done, fail, rd_req;
    logic        rd_ack, rd_valid;
    logic [31:0] di;
    logic        idelay_rst, idelay_ce, idelay_inc;
    logic [7:0]  tap, win_lo, win_hi;

    int passed = 0;
    int total  = 0;

    int passLo   = 20;
    int passHi   = 30;
    int ackDelay = 1;
    bit withhold = 1'b0;

    int cyc       = 0;
    int modelTap  = 0;
    int ceCount   = 0;
    int rstCount  = 0;
    int readCount = 0;
    int reqLen    = 0;
    int viol      = 0;
    int ackEdge   = -1;
    int failEdge  = -1;
    bit prevPulse = 1'b0;
    bit clrMon    = 1'b0;

    hpdmc_dqcal #(
        .TAPS(TAPS), .PATTERN(PATTERN), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .di(di),
        .idelay_rst(idelay_rst), .idelay_ce(idelay_ce), .idelay_inc(idelay_inc),
        .tap(tap), .win_lo(win_lo), .win_hi(win_hi)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Delay-line model and pulse/read bookkeeping, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (clrMon) begin
            ceCount   <= 0;
            rstCount  <= 0;
            readCount <= 0;
            reqLen    <= 0;
            viol      <= 0;
            ackEdge   <= -1;
            failEdge  <= -1;
            prevPulse <= 1'b0;
        end else begin
            if (idelay_ce) ceCount <= ceCount + 1;
            if (idelay_rst) rstCount <= rstCount + 1;
            if (rd_valid) readCount <= readCount + 1;
            if (rd_req) reqLen <= reqLen + 1;
            if (rd_req && rd_ack) ackEdge <= cyc + 1;
            if (fail && failEdge < 0) failEdge <= cyc;
            if ((idelay_ce && idelay_rst) || ((idelay_ce || idelay_rst) && prevPulse)) viol <= viol + 1;
            prevPulse <= idelay_ce || idelay_rst;
        end
        if (idelay_rst) modelTap <= 0;
        else if (idelay_ce) modelTap <= modelTap + 1;
    end

    // Sequencer responder: ack after ackDelay cycles of rd_req, data two cycles later.
    initial begin : responder
        int phase;
        int waitCnt;
        phase = 0;
        waitCnt = 0;
        rd_ack = 1'b0;
        rd_valid = 1'b0;
        di = 32'd0;
        forever begin
            @(posedge sys_clk);
            #1;
            rd_ack = 1'b0;
            rd_valid = 1'b0;
            if (!sys_rst_n) begin
                phase = 0;
                waitCnt = 0;
            end else begin
                case (phase)
                    0: if (rd_req) begin
                        waitCnt++;
                        if (waitCnt >= ackDelay) begin
                            rd_ack = 1'b1;
                            waitCnt = 0;
                            phase = withhold ? 3 : 1;
                        end
                    end
                    1: phase = 2;
                    2: begin
                        rd_valid = 1'b1;
                        di = (modelTap >= passLo && modelTap <= passHi) ? PATTERN : ~PATTERN;
                        phase = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic doReset();
        start = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic clearMonitor();
        clrMon = 1'b1;
        @(negedge sys_clk);
        #1;
        clrMon = 1'b0;
    endtask

    task automatic pulseStart();
        @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit finished;
        finished = 1'b0;
        for (int n = 0; n < budget && !finished; n++) begin
            @(negedge sys_clk);
            if (!busy && (done || fail)) finished = 1'b1;
        end
        repeat (3) @(negedge sys_clk);
        total++;
        if (!finished) $display("[TB] FAIL completion: busy=%0b done=%0b fail=%0b after %0d cycles, required done or fail", busy, done, fail, budget);
        else passed++;
    endtask

    task automatic test_reset();
        start = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset busy: got %0b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL reset done: got %0b want 0", done); else passed++;
        total++; if (fail !== 1'b0) $display("[TB] FAIL reset fail: got %0b want 0", fail); else passed++;
        total++; if (rd_req !== 1'b0) $display("[TB] FAIL reset rd_req: got %0b want 0", rd_req); else passed++;
        total++; if ({idelay_rst, idelay_ce} !== 2'b00) $display("[TB] FAIL reset pulses: got %b want 00", {idelay_rst, idelay_ce}); else passed++;
        total++; if (idelay_inc !== 1'b1) $display("[TB] FAIL reset idelay_inc: got %0b want 1", idelay_inc); else passed++;
        total++; if (tap !== 8'd0) $display("[TB] FAIL reset tap: got %0d want 0", tap); else passed++;
        total++; if ({win_lo, win_hi} !== 16'd0) $display("[TB] FAIL reset window: got %0d..%0d want 0..0", win_lo, win_hi); else passed++;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_window_mid();
        doReset();
        passLo = 20; passHi = 30; ackDelay = 1; withhold = 1'b0;
        clearMonitor();
        pulseStart();
        waitDone(5000);
        total++; if (done !== 1'b1 || fail !== 1'b0) $display("[TB] FAIL mid status: done=%0b fail=%0b want 1/0", done, fail); else passed++;
        total++; if (win_lo !== 8'd20 || win_hi !== 8'd30) $display("[TB] FAIL mid window: got %0d..%0d want 20..30", win_lo, win_hi); else passed++;
        total++; if (tap !== 8'd25) $display("[TB] FAIL mid tap: got %0d want 25", tap); else passed++;
        total++; if (modelTap !== 25) $display("[TB] FAIL mid line tap: got %0d want 25", modelTap); else passed++;
        total++; if (ceCount !== 56) $display("[TB] FAIL mid ce pulses: got %0d want 56", ceCount); else passed++;
        total++; if (rstCount !== 2) $display("[TB] FAIL mid rst pulses: got %0d want 2", rstCount); else passed++;
        total++; if (readCount !== 32 || reqLen !== 32) $display("[TB] FAIL mid reads: got %0d reads %0d req cycles want 32/32", readCount, reqLen); else passed++;
        total++; if (viol !== 0) $display("[TB] FAIL mid pulse spacing: got %0d violations want 0", viol); else passed++;
    endtask

    task automatic test_never_pass();
        doReset();
        passLo = 200; passHi = 0; ackDelay = 1; withhold = 1'b0;
        clearMonitor();
        pulseStart();
        waitDone(5000);
        total++; if (fail !== 1'b1 || done !== 1'b0) $display("[TB] FAIL never status: done=%0b fail=%0b want 0/1", done, fail); else passed++;
        total++; if (readCount !== 64) $display("[TB] FAIL never reads: got %0d want 64", readCount); else passed++;
        total++; if (ceCount !== 63 || rstCount !== 1) $display("[TB] FAIL never pulses: ce=%0d rst=%0d want 63/1", ceCount, rstCount); else passed++;
        total++; if (tap !== 8'd63) $display("[TB] FAIL never tap: got %0d want 63", tap); else passed++;
    endtask

    task automatic test_window_end();
        doReset();
        passLo = 60; passHi = 63; ackDelay = 1; withhold = 1'b0;
        clearMonitor();
        pulseStart();
        waitDone(5000);
        total++; if (done !== 1'b1 || fail !== 1'b0) $display("[TB] FAIL end status: done=%0b fail=%0b want 1/0", done, fail); else passed++;
        total++; if (win_lo !== 8'd60 || win_hi !== 8'd63) $display("[TB] FAIL end window: got %0d..%0d want 60..63", win_lo, win_hi); else passed++;
        total++; if (tap !== 8'd61) $display("[TB] FAIL end tap: got %0d want 61", tap); else passed++;
        total++; if (ceCount !== 124 || rstCount !== 2) $display("[TB] FAIL end pulses: ce=%0d rst=%0d want 124/2", ceCount, rstCount); else passed++;
        total++; if (readCount !== 64) $display("[TB] FAIL end reads: got %0d want 64", readCount); else passed++;
    endtask

    task automatic test_timeout();
        doReset();
        passLo = 20; passHi = 30; ackDelay = 5; withhold = 1'b1;
        clearMonitor();
        pulseStart();
        waitDone(1000);
        total++; if (fail !== 1'b1 || done !== 1'b0) $display("[TB] FAIL timeout status: done=%0b fail=%0b want 0/1", done, fail); else passed++;
        total++; if (reqLen !== 5) $display("[TB] FAIL timeout rd_req length: got %0d want 5", reqLen); else passed++;
        total++; if (failEdge - ackEdge !== TIMEOUT) $display("[TB] FAIL timeout latency: got %0d want %0d", failEdge - ackEdge, TIMEOUT); else passed++;
        total++; if (readCount !== 0 || tap !== 8'd0) $display("[TB] FAIL timeout state: reads=%0d tap=%0d want 0/0", readCount, tap); else passed++;
        ackDelay = 1; withhold = 1'b0;
    endtask

    task automatic test_reset_mid_center();
        bit reached;
        int ceAtReset;
        int rstAtReset;
        doReset();
        passLo = 20; passHi = 30; ackDelay = 1; withhold = 1'b0;
        clearMonitor();
        pulseStart();
        reached = 1'b0;
        for (int n = 0; n < 5000 && !reached; n++) begin
            @(negedge sys_clk);
            #1;
            if (rstCount == 2 && modelTap == 7) reached = 1'b1;
        end
        total++; if (!reached) $display("[TB] FAIL center reach: line tap %0d rst pulses %0d, required tap 7 after rezero", modelTap, rstCount); else passed++;
        repeat (5) @(negedge sys_clk);
        total++; if (tap !== 8'd7 || busy !== 1'b1) $display("[TB] FAIL center position: tap=%0d busy=%0b want 7/1", tap, busy); else passed++;
        sys_rst_n = 1'b0;
        #1;
        ceAtReset = ceCount;
        rstAtReset = rstCount;
        total++; if ({busy, done, fail, rd_req, idelay_rst, idelay_ce} !== 6'b0) $display("[TB] FAIL abort outputs: got %b want 000000", {busy, done, fail, rd_req, idelay_rst, idelay_ce}); else passed++;
        total++; if ({tap, win_lo, win_hi} !== 24'd0) $display("[TB] FAIL abort tap/window: got %0d %0d %0d want 0 0 0", tap, win_lo, win_hi); else passed++;
        repeat (4) @(negedge sys_clk);
        total++; if (ceCount !== ceAtReset || rstCount !== rstAtReset) $display("[TB] FAIL abort pulses: ce %0d->%0d rst %0d->%0d want unchanged", ceAtReset, ceCount, rstAtReset, rstCount); else passed++;
        sys_rst_n = 1'b1;
        clearMonitor();
        pulseStart();
        waitDone(5000);
        total++; if (done !== 1'b1 || win_lo !== 8'd20 || win_hi !== 8'd30 || tap !== 8'd25) $display("[TB] FAIL rerun result: done=%0b win=%0d..%0d tap=%0d want 1 20..30 25", done, win_lo, win_hi, tap); else passed++;
    endtask

    task automatic test_start_while_busy();
        doReset();
        passLo = 20; passHi = 30; ackDelay = 1; withhold = 1'b0;
        clearMonitor();
        pulseStart();
        repeat (100) @(negedge sys_clk);
        total++; if (busy !== 1'b1) $display("[TB] FAIL busy during sweep: got %0b want 1", busy); else passed++;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        waitDone(5000);
        total++; if (done !== 1'b1 || win_lo !== 8'd20 || win_hi !== 8'd30 || tap !== 8'd25) $display("[TB] FAIL restart result: done=%0b win=%0d..%0d tap=%0d want 1 20..30 25", done, win_lo, win_hi, tap); else passed++;
        total++; if (ceCount !== 56 || rstCount !== 2 || readCount !== 32) $display("[TB] FAIL restart counts: ce=%0d rst=%0d reads=%0d want 56/2/32", ceCount, rstCount, readCount); else passed++;
    endtask

    initial begin
        start = 1'b0;
        sys_rst_n = 1'b0;
        test_reset();
        test_window_mid();
        test_never_pass();
        test_window_end();
        test_timeout();
        test_reset_mid_center();
        test_start_while_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hpdmc_dqcal.md
HPDMC_DQCAL -- requirements
Module: hpdmc_dqcal

Interface
REQ-001 SHALL have parameter TAPS, default 64, meaning number of delay taps swept (2..255).
REQ-002 SHALL have parameter PATTERN, default 32'hA55A5AA5, meaning expected test-read word.
REQ-003 SHALL have parameter SETTLE, default 4, meaning idle cycles after each delay step (1..15).
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for rd_valid (1..255).
REQ-005 SHALL have port sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle pulse; begins calibration when idle.
REQ-008 SHALL have port busy  out  1  high from start acceptance until done or fail.
REQ-009 SHALL have port done  out  1  sticky; calibration succeeded.
REQ-010 SHALL have port fail  out  1  sticky; no passing tap, or read timeout.
REQ-011 SHALL have port rd_req  out  1  test-read request to the sequencer.
REQ-012 SHALL have port rd_ack  in  1  sequencer accepted the request.
REQ-013 SHALL have port rd_valid  in  1  one-cycle strobe; di holds captured word.
REQ-014 SHALL have port di  in  32  captured read data.
REQ-015 SHALL have port idelay_rst  out  1  one-cycle pulse; delay line returns to tap 0.
REQ-016 SHALL have port idelay_ce  out  1  one-cycle pulse; step delay line by one tap.
REQ-017 SHALL have port idelay_inc  out  1  step direction; constant 1 (increment only).
REQ-018 SHALL have port tap  out  8  current tap position of the delay line.
REQ-019 SHALL have port win_lo / win_hi  out  8 each  first/last passing tap of the window.

Function
REQ-020 SHALL implement states IDLE, ZERO, REQ, WAIT, STEP, SETTLE, REZERO, CENTER, CSETTLE, END.
REQ-021 IDLE: start -> ZERO; clears done, fail, win_lo, win_hi, found; start ignored in any other state.
REQ-022 ZERO: idelay_rst high one cycle, tap := 0, -> SETTLE (counter = SETTLE).
REQ-023 SETTLE: count down; at 0 -> REQ.
REQ-024 REQ: rd_req held high until the cycle rd_ack is high; next cycle rd_req low, timeout counter loaded, -> WAIT.
REQ-025 WAIT: rd_valid with di == PATTERN is a pass; any other di is a miss; if no rd_valid within TIMEOUT cycles -> END with fail=1.
REQ-026 Pass with found=0: win_lo := tap, win_hi := tap, found := 1; pass with found=1: win_hi := tap.
REQ-027 Miss with found=1 closes the window -> REZERO; miss with found=0 continues.
REQ-028 After a pass or miss that does not close the window: if tap == TAPS-1 -> (found ? REZERO : END with fail=1), else -> STEP.
REQ-029 STEP: idelay_ce high one cycle, tap := tap+1, -> SETTLE.
REQ-030 REZERO: idelay_rst pulse, tap := 0, target := (win_lo + win_hi) >> 1 computed in 9 bits, -> CSETTLE.
REQ-031 CENTER: if tap == target -> END with done=1; else idelay_ce pulse, tap+1, -> CSETTLE.
REQ-032 CSETTLE: SETTLE-cycle countdown, then -> CENTER.
REQ-033 END: busy low, done/fail held, -> IDLE same cycle; tap retains final value.
REQ-034 idelay_rst and idelay_ce SHALL never be high in the same cycle, nor for more than one consecutive cycle.
REQ-035 rd_valid outside WAIT SHALL be ignored; rd_valid and timeout expiry in the same cycle count as rd_valid.
REQ-036 Only the first contiguous passing window is measured; later passes are not evaluated.
REQ-037 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-038 sys_rst_n low SHALL asynchronously force IDLE, busy=0, done=0, fail=0, rd_req=0, idelay_rst=0, idelay_ce=0, tap=0, win_lo=0, win_hi=0; idelay_inc stays 1.
REQ-039 Reset mid-calibration SHALL abort without issuing further idelay pulses; the next start re-runs from ZERO.

Verification
REQ-040 TAPS=64, model passes taps 20..30 -> win_lo=20, win_hi=30, final tap=25, done=1, 31+25 ce pulses, 2 rst pulses.
REQ-041 Model never passes -> 64 reads, 63 ce pulses, fail=1, done=0, tap=63.
REQ-042 Model passes taps 60..63 -> window closes at end, win_lo=60, win_hi=63, final tap=61, done=1.
REQ-043 rd_ack delayed 5 cycles and rd_valid withheld -> rd_req held 5 cycles, fail=1 exactly TIMEOUT cycles after ack.
REQ-044 sys_rst_n asserted during CENTER at tap 7 -> all outputs at reset values immediately; new start gives correct result.
REQ-045 start pulsed while busy -> ignored; result identical to run without the extra pulse.
